pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 170 +++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard and redirect controller for a five-stage pipeline: stage stall/flush,
// redirect PC selection, operand bypassing and a memory-wait timeout.
module pipeline_hazard_controller #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      decRs1Addr,
  input  logic [4:0]      decRs2Addr,
  input  logic            decRs1Used,
  input  logic            decRs2Used,
  input  logic [4:0]      exRs1Addr,
  input  logic [4:0]      exRs2Addr,
  input  logic [XLEN-1:0] exRs1Data,
  input  logic [XLEN-1:0] exRs2Data,
  input  logic [4:0]      exRdAddr,
  input  logic            exWbEnable,
  input  logic            exIsLoad,
  input  logic [4:0]      memRdAddr,
  input  logic            memWbEnable,
  input  logic [XLEN-1:0] memResult,
  input  logic [4:0]      wbRdAddr,
  input  logic            wbWbEnable,
  input  logic [XLEN-1:0] wbResult,
  input  logic            brMispredict,
  input  logic [XLEN-1:0] brTarget,
  input  logic            trapReq,
  input  logic [XLEN-1:0] trapVector,
  input  logic            memBusy,
  output logic [XLEN-1:0] irregPc,
  output logic            irregPcValid,
  output logic            fetchStall,
  output logic            fetchFlush,
  output logic            fetchVirtualStall,
  output logic            fetchVirtualFlush,
  output logic            decodeStall,
  output logic            decodeFlush,
  output logic            executeStall,
  output logic            executeFlush,
  output logic            memStall,
  output logic            memFlush,
  output logic [XLEN-1:0] bypassedRs1,
  output logic [XLEN-1:0] bypassedRs2,
  output logic            memTimeout
);

  // RUN: normal flow; HOLD: memory wait, nothing pending;
  // REDIRECT: memory wait (or its last cycle) with a mispredict target parked.
  typedef enum logic [1:0] {RUN, HOLD, REDIRECT} state_t;

  localparam logic [7:0] TMO_MAX = 8'(MEM_TIMEOUT);
  localparam logic [7:0] TMO_PRE = 8'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              pending_valid_q, pending_valid_d;
  logic [XLEN-1:0]   pending_pc_q, pending_pc_d;
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;
  logic              load_use_q, load_use_d;
  logic              load_use_hit;

  assign load_use_hit = exIsLoad && exWbEnable && (exRdAddr != 5'd0) &&
                        ((decRs1Used && (decRs1Addr == exRdAddr)) ||
                         (decRs2Used && (decRs2Addr == exRdAddr)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= RUN;
      pending_valid_q <= 1'b0;
      pending_pc_q    <= '0;
      tmo_cnt_q       <= '0;
      load_use_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_valid_q <= pending_valid_d;
      pending_pc_q    <= pending_pc_d;
      tmo_cnt_q       <= tmo_cnt_d;
      load_use_q      <= load_use_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    pending_valid_d   = pending_valid_q;
    pending_pc_d      = pending_pc_q;
    load_use_d        = 1'b0;
    irregPc           = '0;
    irregPcValid      = 1'b0;
    fetchStall        = 1'b0;
    fetchFlush        = 1'b0;
    fetchVirtualStall = 1'b0;
    fetchVirtualFlush = 1'b0;
    decodeStall       = 1'b0;
    decodeFlush       = 1'b0;
    executeStall      = 1'b0;
    executeFlush      = 1'b0;
    memStall          = 1'b0;
    memFlush          = 1'b0;
    if (!rst) begin
      if (trapReq) begin
        irregPc           = trapVector;
        irregPcValid      = 1'b1;
        fetchVirtualFlush = 1'b1;
        decodeFlush       = 1'b1;
        executeFlush      = 1'b1;
        memFlush          = 1'b1;
        pending_valid_d   = 1'b0;
        state_d           = RUN;
      end else if (memBusy) begin
        fetchStall        = 1'b1;
        fetchVirtualStall = 1'b1;
        decodeStall       = 1'b1;
        executeStall      = 1'b1;
        memStall          = 1'b1;
        // Only the oldest mispredict matters; younger ones are on a wrong path.
        if (brMispredict && !pending_valid_q) begin
          pending_valid_d = 1'b1;
          pending_pc_d    = brTarget;
        end
        state_d = pending_valid_d ? REDIRECT : HOLD;
      end else if (state_q == REDIRECT) begin
        irregPc           = pending_pc_q;
        irregPcValid      = 1'b1;
        fetchVirtualFlush = 1'b1;
        decodeFlush       = 1'b1;
        executeFlush      = 1'b1;
        pending_valid_d   = 1'b0;
        state_d           = RUN;
      end else begin
        state_d = RUN;
        if (brMispredict) begin
          irregPc           = brTarget;
          irregPcValid      = 1'b1;
          fetchVirtualFlush = 1'b1;
          decodeFlush       = 1'b1;
          executeFlush      = 1'b1;
        end else if (load_use_hit && !load_use_q) begin
          // The bubble removes the load from execute, so one cycle suffices.
          fetchStall        = 1'b1;
          fetchVirtualStall = 1'b1;
          decodeStall       = 1'b1;
          executeFlush      = 1'b1;
          load_use_d        = 1'b1;
        end
      end
    end
  end

  always_comb begin
    tmo_cnt_d = '0;
    if (memBusy) begin
      tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 8'd1;
    end
    memTimeout = !rst && memBusy && (tmo_cnt_q == TMO_PRE);
  end

  always_comb begin
    bypassedRs1 = exRs1Data;
    if (exRs1Addr != 5'd0) begin
      if (memWbEnable && (memRdAddr == exRs1Addr))     bypassedRs1 = memResult;
      else if (wbWbEnable && (wbRdAddr == exRs1Addr))  bypassedRs1 = wbResult;
    end
    bypassedRs2 = exRs2Data;
    if (exRs2Addr != 5'd0) begin
      if (memWbEnable && (memRdAddr == exRs2Addr))     bypassedRs2 = memResult;
      else if (wbWbEnable && (wbRdAddr == exRs2Addr))  bypassedRs2 = wbResult;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: per-cycle expectations are
// queued with the stimulus and compared at the falling edge.
module tb_pipeline_hazard_controller;

  logic        clk, rst;
  logic [4:0]  decRs1Addr, decRs2Addr, exRs1Addr, exRs2Addr, exRdAddr, memRdAddr, wbRdAddr;
  logic        decRs1Used, decRs2Used, exWbEnable, exIsLoad, memWbEnable, wbWbEnable;
  logic [31:0] exRs1Data, exRs2Data, memResult, wbResult, brTarget, trapVector;
  logic        brMispredict, trapReq, memBusy;
  logic [31:0] irregPc, bypassedRs1, bypassedRs2;
  logic        irregPcValid, memTimeout;
  logic        fetchStall, fetchFlush, fetchVirtualStall, fetchVirtualFlush;
  logic        decodeStall, decodeFlush, executeStall, executeFlush, memStall, memFlush;

  pipeline_hazard_controller #(.XLEN(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .decRs1Addr(decRs1Addr), .decRs2Addr(decRs2Addr),
    .decRs1Used(decRs1Used), .decRs2Used(decRs2Used),
    .exRs1Addr(exRs1Addr), .exRs2Addr(exRs2Addr),
    .exRs1Data(exRs1Data), .exRs2Data(exRs2Data),
    .exRdAddr(exRdAddr), .exWbEnable(exWbEnable), .exIsLoad(exIsLoad),
    .memRdAddr(memRdAddr), .memWbEnable(memWbEnable), .memResult(memResult),
    .wbRdAddr(wbRdAddr), .wbWbEnable(wbWbEnable), .wbResult(wbResult),
    .brMispredict(brMispredict), .brTarget(brTarget),
    .trapReq(trapReq), .trapVector(trapVector), .memBusy(memBusy),
    .irregPc(irregPc), .irregPcValid(irregPcValid),
    .fetchStall(fetchStall), .fetchFlush(fetchFlush),
    .fetchVirtualStall(fetchVirtualStall), .fetchVirtualFlush(fetchVirtualFlush),
    .decodeStall(decodeStall), .decodeFlush(decodeFlush),
    .executeStall(executeStall), .executeFlush(executeFlush),
    .memStall(memStall), .memFlush(memFlush),
    .bypassedRs1(bypassedRs1), .bypassedRs2(bypassedRs2),
    .memTimeout(memTimeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  stall;   // {fetch, fetchVirtual, decode, execute, mem}
    logic [4:0]  flush;
    logic        tmo;
    logic [31:0] b1;
    logic [31:0] b2;
  } exp_t;

  localparam logic [4:0] NONE   = 5'b00000;
  localparam logic [4:0] ALL    = 5'b11111;
  localparam logic [4:0] RD_FL  = 5'b01110;
  localparam logic [4:0] TRP_FL = 5'b01111;
  localparam logic [4:0] LU_ST  = 5'b11100;
  localparam logic [4:0] LU_FL  = 5'b00010;

  exp_t sb[$];
  logic mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  wire [4:0] act_stall = {fetchStall, fetchVirtualStall, decodeStall, executeStall, memStall};
  wire [4:0] act_flush = {fetchFlush, fetchVirtualFlush, decodeFlush, executeFlush, memFlush};

  function automatic logic [31:0] ref_bp(input logic [4:0] a, input logic [31:0] d);
    if (a == 5'd0) return d;
    if (memWbEnable && memRdAddr == a) return memResult;
    if (wbWbEnable && wbRdAddr == a) return wbResult;
    return d;
  endfunction

  function automatic exp_t mk(input string tag, input logic v, input logic [31:0] pc,
                              input logic [4:0] st, input logic [4:0] fl, input logic t);
    exp_t e;
    e.tag = tag; e.valid = v; e.pc = pc; e.stall = st; e.flush = fl; e.tmo = t;
    e.b1 = ref_bp(exRs1Addr, exRs1Data);
    e.b2 = ref_bp(exRs2Addr, exRs2Data);
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_en && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks += 6;
      if (irregPcValid !== e.valid) begin
        errors++; $display("FAIL %s irregPcValid: got %0b expected %0b", e.tag, irregPcValid, e.valid);
      end
      if (e.valid) begin
        checks++;
        if (irregPc !== e.pc) begin
          errors++; $display("FAIL %s irregPc: got %h expected %h", e.tag, irregPc, e.pc);
        end
      end
      if (act_stall !== e.stall) begin
        errors++; $display("FAIL %s stalls: got %b expected %b", e.tag, act_stall, e.stall);
      end
      if (act_flush !== e.flush) begin
        errors++; $display("FAIL %s flushes: got %b expected %b", e.tag, act_flush, e.flush);
      end
      if (memTimeout !== e.tmo) begin
        errors++; $display("FAIL %s memTimeout: got %0b expected %0b", e.tag, memTimeout, e.tmo);
      end
      if (bypassedRs1 !== e.b1) begin
        errors++; $display("FAIL %s bypassedRs1: got %h expected %h", e.tag, bypassedRs1, e.b1);
      end
      if (bypassedRs2 !== e.b2) begin
        errors++; $display("FAIL %s bypassedRs2: got %h expected %h", e.tag, bypassedRs2, e.b2);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    decRs1Addr = 5'd0; decRs2Addr = 5'd0; decRs1Used = 1'b0; decRs2Used = 1'b0;
    exRs1Addr = 5'd0; exRs2Addr = 5'd0;
    exRs1Data = 32'h1111_1111; exRs2Data = 32'h2222_2222;
    exRdAddr = 5'd0; exWbEnable = 1'b0; exIsLoad = 1'b0;
    memRdAddr = 5'd0; memWbEnable = 1'b0; memResult = 32'hAAAA_0001;
    wbRdAddr = 5'd0; wbWbEnable = 1'b0; wbResult = 32'hBBBB_0002;
    brMispredict = 1'b0; brTarget = 32'h0; trapReq = 1'b0; trapVector = 32'h0;
    memBusy = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    memBusy = 1'b1; trapReq = 1'b1; trapVector = 32'h80;
    brMispredict = 1'b1; brTarget = 32'h44;
    memRdAddr = 5'd3; memWbEnable = 1'b1; exRs1Addr = 5'd3;
    #2;
    checks += 5;
    if (irregPcValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", irregPcValid); end
    if (act_stall !== NONE) begin errors++; $display("FAIL reset_stall: got %b expected 00000", act_stall); end
    if (act_flush !== NONE) begin errors++; $display("FAIL reset_flush: got %b expected 00000", act_flush); end
    if (memTimeout !== 1'b0) begin errors++; $display("FAIL reset_tmo: got %0b expected 0", memTimeout); end
    if (bypassedRs1 !== memResult) begin errors++; $display("FAIL reset_bypass: got %h expected %h", bypassedRs1, memResult); end
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++;
    if (memTimeout !== 1'b0) begin errors++; $display("FAIL reset_tmo_clocked: got %0b expected 0", memTimeout); end
    clear_inputs();
    rst = 1'b0;
    next_cycle();
    mon_en = 1'b1;
    sb.push_back(mk("post_reset_idle", 0, 0, NONE, NONE, 0));
    next_cycle();
  endtask

  task automatic test_load_use();
    clear_inputs();
    exIsLoad = 1'b1; exWbEnable = 1'b1; exRdAddr = 5'd5; decRs1Addr = 5'd5; decRs1Used = 1'b1;
    sb.push_back(mk("lu_rs1_stall", 0, 0, LU_ST, LU_FL, 0));
    next_cycle();
    sb.push_back(mk("lu_rs1_once", 0, 0, NONE, NONE, 0));
    next_cycle();
    exRdAddr = 5'd0; decRs1Addr = 5'd0;
    sb.push_back(mk("lu_x0", 0, 0, NONE, NONE, 0));
    next_cycle();
    exRdAddr = 5'd9; decRs1Addr = 5'd1; decRs2Addr = 5'd9; decRs2Used = 1'b0;
    sb.push_back(mk("lu_rs2_unused", 0, 0, NONE, NONE, 0));
    next_cycle();
    decRs2Used = 1'b1;
    sb.push_back(mk("lu_rs2_stall", 0, 0, LU_ST, LU_FL, 0));
    next_cycle();
    exIsLoad = 1'b0;
    sb.push_back(mk("lu_not_load", 0, 0, NONE, NONE, 0));
    next_cycle();
    clear_inputs();
    sb.push_back(mk("lu_idle", 0, 0, NONE, NONE, 0));
    next_cycle();
  endtask

  task automatic test_mispredict_run();
    clear_inputs();
    brMispredict = 1'b1; brTarget = 32'h44;
    sb.push_back(mk("br_run", 1, 32'h44, NONE, RD_FL, 0));
    next_cycle();
    exIsLoad = 1'b1; exWbEnable = 1'b1; exRdAddr = 5'd7; decRs1Addr = 5'd7; decRs1Used = 1'b1;
    brTarget = 32'h48;
    sb.push_back(mk("br_over_loaduse", 1, 32'h48, NONE, RD_FL, 0));
    next_cycle();
    clear_inputs();
    sb.push_back(mk("br_idle", 0, 0, NONE, NONE, 0));
    next_cycle();
  endtask

  task automatic test_mispredict_busy();
    clear_inputs();
    for (int c = 1; c <= 4; c++) begin
      memBusy = 1'b1;
      brMispredict = (c == 2) || (c == 3);
      brTarget = (c == 2) ? 32'h100 : 32'h300;
      sb.push_back(mk($sformatf("busy_br_c%0d", c), 0, 0, ALL, NONE, c == 4));
      next_cycle();
    end
    memBusy = 1'b0; brMispredict = 1'b1; brTarget = 32'h500;
    sb.push_back(mk("pending_issue", 1, 32'h100, NONE, RD_FL, 0));
    next_cycle();
    clear_inputs();
    sb.push_back(mk("pending_done", 0, 0, NONE, NONE, 0));
    next_cycle();
  endtask

  task automatic test_trap_priority();
    clear_inputs();
    trapReq = 1'b1; trapVector = 32'h80; brMispredict = 1'b1; brTarget = 32'h200;
    sb.push_back(mk("trap_vs_br", 1, 32'h80, NONE, TRP_FL, 0));
    next_cycle();
    clear_inputs();
    memBusy = 1'b1; brMispredict = 1'b1; brTarget = 32'h600;
    sb.push_back(mk("trap_busy_c1", 0, 0, ALL, NONE, 0));
    next_cycle();
    brMispredict = 1'b0;
    sb.push_back(mk("trap_busy_c2", 0, 0, ALL, NONE, 0));
    next_cycle();
    trapReq = 1'b1; trapVector = 32'h80;
    sb.push_back(mk("trap_over_busy", 1, 32'h80, NONE, TRP_FL, 0));
    next_cycle();
    clear_inputs();
    sb.push_back(mk("trap_drops_pending", 0, 0, NONE, NONE, 0));
    next_cycle();
  endtask

  task automatic test_bypass();
    clear_inputs();
    memRdAddr = 5'd3; memWbEnable = 1'b1; memResult = 32'hCAFE_0003;
    wbRdAddr = 5'd3; wbWbEnable = 1'b1; wbResult = 32'hBEEF_0003;
    exRs1Addr = 5'd3; exRs2Addr = 5'd0;
    sb.push_back(mk("bp_mem_first", 0, 0, NONE, NONE, 0));
    checks += 2;
    #1;
    if (bypassedRs1 !== 32'hCAFE_0003) begin errors++; $display("FAIL bp_rs1_mem: got %h expected cafe0003", bypassedRs1); end
    if (bypassedRs2 !== 32'h2222_2222) begin errors++; $display("FAIL bp_rs2_x0: got %h expected 22222222", bypassedRs2); end
    next_cycle();
    memWbEnable = 1'b0; exRs2Addr = 5'd3;
    sb.push_back(mk("bp_wb_only", 0, 0, NONE, NONE, 0));
    next_cycle();
    memRdAddr = 5'd0; memWbEnable = 1'b1; exRs1Addr = 5'd0;
    sb.push_back(mk("bp_x0_mem", 0, 0, NONE, NONE, 0));
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      exRs1Addr = 5'($urandom_range(0, 3)); exRs2Addr = 5'($urandom_range(0, 3));
      memRdAddr = 5'($urandom_range(0, 3)); wbRdAddr = 5'($urandom_range(0, 3));
      memWbEnable = 1'($urandom_range(0, 1)); wbWbEnable = 1'($urandom_range(0, 1));
      exRs1Data = $urandom; exRs2Data = $urandom; memResult = $urandom; wbResult = $urandom;
      sb.push_back(mk($sformatf("bp_rand%0d", i), 0, 0, NONE, NONE, 0));
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int at = 0;
    clear_inputs();
    sb.push_back(mk("tmo_pre_idle", 0, 0, NONE, NONE, 0));
    next_cycle();
    for (int c = 1; c <= 10; c++) begin
      memBusy = 1'b1;
      sb.push_back(mk($sformatf("tmo_c%0d", c), 0, 0, ALL, NONE, c == 4));
      #1;
      if (memTimeout) begin pulses++; at = c; end
      next_cycle();
    end
    checks += 2;
    if (pulses != 1) begin errors++; $display("FAIL tmo_pulse_count: got %0d expected 1", pulses); end
    if (at != 4) begin errors++; $display("FAIL tmo_pulse_cycle: got %0d expected 4", at); end
    memBusy = 1'b0;
    sb.push_back(mk("tmo_release", 0, 0, NONE, NONE, 0));
    next_cycle();
    for (int c = 1; c <= 5; c++) begin
      memBusy = 1'b1;
      sb.push_back(mk($sformatf("tmo_again_c%0d", c), 0, 0, ALL, NONE, c == 4));
      next_cycle();
    end
    clear_inputs();
    sb.push_back(mk("tmo_end", 0, 0, NONE, NONE, 0));
    next_cycle();
  endtask

  task automatic test_reset_mid_hold();
    clear_inputs();
    memBusy = 1'b1; brMispredict = 1'b1; brTarget = 32'h700;
    sb.push_back(mk("rh_busy_c1", 0, 0, ALL, NONE, 0));
    next_cycle();
    brMispredict = 1'b0;
    sb.push_back(mk("rh_busy_c2", 0, 0, ALL, NONE, 0));
    next_cycle();
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks += 2;
    if (act_stall !== NONE) begin errors++; $display("FAIL rh_reset_stall: got %b expected 00000", act_stall); end
    if (irregPcValid !== 1'b0) begin errors++; $display("FAIL rh_reset_valid: got %0b expected 0", irregPcValid); end
    #1;
    memBusy = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (irregPcValid !== 1'b0) begin
      errors++; $display("FAIL rh_no_redirect: got valid %0b pc %h expected 0", irregPcValid, irregPc);
    end
    next_cycle();
    mon_en = 1'b1;
    sb.push_back(mk("rh_after1", 0, 0, NONE, NONE, 0));
    next_cycle();
    sb.push_back(mk("rh_after2", 0, 0, NONE, NONE, 0));
    next_cycle();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_mispredict_run();
    test_mispredict_busy();
    test_trap_priority();
    test_bypass();
    test_timeout();
    test_reset_mid_hold();
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
